// File: rtl/usart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usart_tx_arbiter
//   Packet-level round-robin arbiter that shares one USART TX byte stream among
//   NUM_REQ requesters. Ownership is held for a whole packet, so bytes from
//   different requesters never interleave on the serial line. Ownership ends on:
//     - a handshake carrying s_last,
//     - the MAX_LEN-th handshake (trunc pulses if s_last was not set), or
//     - TIMEOUT consecutive idle cycles of the owner (only with UART_ARB_TIMEOUT_EN).
//
// Optional feature macro: UART_ARB_TIMEOUT_EN (idle-timeout release).
//
// Ports
//   clk      system clock
//   rst_n    synchronous active-low reset
//   s_valid  per-requester byte valid            [NUM_REQ]
//   s_last   per-requester last-byte flag        [NUM_REQ]
//   s_data   per-requester byte, req i at [8i+7:8i]
//   s_ready  per-requester accept                [NUM_REQ]
//   m_valid  byte valid to USART TX
//   m_data   byte to USART TX
//   m_ready  USART TX can accept a byte
//   grant    one-hot current owner, 0 when idle (registered)
//   busy     a packet transfer is in progress
//   trunc    1-cycle pulse: released by MAX_LEN limit
//   timeout  1-cycle pulse: released by idle timeout
// -----------------------------------------------------------------------------
module usart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   s_valid,
    input  logic [NUM_REQ-1:0]   s_last,
    input  logic [NUM_REQ*8-1:0] s_data,
    output logic [NUM_REQ-1:0]   s_ready,
    output logic                 m_valid,
    output logic [7:0]           m_data,
    input  logic                 m_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 trunc,
    output logic                 timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Reject parameter sets the arbiter is not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LEN < 1 || TIMEOUT < 1) begin : g_param_check
        $error("usart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [LEN_W-1:0]   len_cnt_r;
    logic               trunc_r;
    logic               timeout_r;

    logic [PTR_W-1:0]   sel_s;
    logic [PTR_W-1:0]   pick_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic               pick_found_s;
    logic [7:0]         sel_data_s;
    logic               xfer_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               hs_s;
    logic               rel_last_s;
    logic               rel_max_s;
    logic               rel_tmo_s;
    logic               release_s;

    // Decode the one-hot owner into an index and select its byte.
    always_comb begin
        sel_s      = '0;
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r[i]) begin
                sel_s      = PTR_W'(i);
                sel_data_s = s_data[8*i +: 8];
            end else begin
                sel_s      = sel_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Round-robin search: first asserted s_valid at or after rr_ptr, wrapping.
    // Iterating from the farthest slot down lets the nearest hit win.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (|((s_valid >> ((int'(rr_ptr_r) + k) % NUM_REQ)) & NUM_REQ'(1))) begin
                pick_found_s = 1'b1;
                pick_s       = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            end else begin
                pick_found_s = pick_found_s;
                pick_s       = pick_s;
            end
        end
    end

    // grant_r is one-hot (or zero), so masking and OR-reducing selects the owner's bit.
    assign xfer_s      = (state_r == ST_XFER);
    assign sel_valid_s = xfer_s & (|(s_valid & grant_r));
    assign sel_last_s  = |(s_last & grant_r);
    assign hs_s        = sel_valid_s & m_ready;
    assign next_ptr_s  = (sel_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(0) : (sel_s + PTR_W'(1));

    assign rel_last_s = hs_s & sel_last_s;
    // len_cnt_r still holds the count before this handshake, so MAX_LEN-1 marks the MAX_LEN-th byte.
    assign rel_max_s  = hs_s & ~sel_last_s & (len_cnt_r == LEN_W'(MAX_LEN - 1));
    assign release_s  = rel_last_s | rel_max_s | rel_tmo_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] idle_cnt_r;

    assign rel_tmo_s = xfer_s & ~sel_valid_s & (idle_cnt_r == TMO_W'(TIMEOUT - 1));

    // Count consecutive cycles the owner has nothing to send; any byte offered restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (!xfer_s || sel_valid_s || release_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TMO_W'(1);
        end
    end
`else
    assign rel_tmo_s = 1'b0;
`endif

    // Arbitration FSM: grant ownership in IDLE, track packet length and release in XFER.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            rr_ptr_r  <= '0;
            len_cnt_r <= '0;
            trunc_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            trunc_r   <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r   <= ST_XFER;
                        grant_r   <= NUM_REQ'(1) << pick_s;
                        len_cnt_r <= '0;
                    end else begin
                        grant_r   <= '0;
                    end
                end
                ST_XFER: begin
                    if (release_s) begin
                        state_r   <= ST_IDLE;
                        grant_r   <= '0;
                        len_cnt_r <= '0;
                        rr_ptr_r  <= next_ptr_s;
                        trunc_r   <= rel_max_s;
                        timeout_r <= rel_tmo_s;
                    end else if (hs_s) begin
                        len_cnt_r <= len_cnt_r + LEN_W'(1);
                    end else begin
                        len_cnt_r <= len_cnt_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= '0;
                    len_cnt_r <= '0;
                end
            endcase
        end
    end

    // Byte path follows the registered owner; nothing moves while idle.
    assign m_valid = sel_valid_s;
    assign m_data  = xfer_s ? sel_data_s : 8'h00;
    assign s_ready = (xfer_s & m_ready) ? grant_r : '0;
    assign grant   = grant_r;
    assign busy    = xfer_s;
    assign trunc   = trunc_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
module tb_usart_tx_arbiter;

    localparam int N       = 4;
    localparam int MAXLEN  = 16;
    localparam int TMO     = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] s_valid;
    logic [N-1:0] s_last;
    logic [N*8-1:0] s_data;
    logic [N-1:0] s_ready;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_ready;
    logic [N-1:0] grant;
    logic         busy;
    logic         trunc;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Per-requester byte streams for the randomized scenario: {last, data}.
    logic [8:0] mem [N][96];
    int rd [N];
    int wr [N];

    usart_tx_arbiter #(.NUM_REQ(N), .MAX_LEN(MAXLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .grant(grant), .busy(busy), .trunc(trunc), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one clock: through the active edge, then to the opposite edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 4'b1111; s_last = '0; s_data = '0; m_ready = 1'b0;
        step(); step();
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected %b", grant, 4'b0000); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_s_ready: got %b expected 0000", s_ready); end
        checks++; if (busy !== 1'b0 || trunc !== 1'b0 || timeout !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL rst_misc: busy=%b trunc=%b timeout=%b m_data=%h expected all 0", busy, trunc, timeout, m_data);
        end
        rst_n = 1'b1;
        step(); #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected %b", grant, 4'b0001); end
        s_last = 4'b1111; m_ready = 1'b1;
        step();
        s_valid = '0; s_last = '0;
        step();
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [3];
        bytes[0] = 8'hAA; bytes[1] = 8'h55; bytes[2] = 8'h0F;
        do_reset();
        s_valid = 4'b0010; s_data[15:8] = bytes[0]; m_ready = 1'b1;
        step();
        for (int b = 0; b < 3; b++) begin
            s_data[15:8] = bytes[b]; s_last[1] = (b == 2);
            #1;
            checks++; if (grant !== 4'b0010 || m_valid !== 1'b1 || m_data !== bytes[b] || s_ready !== 4'b0010) begin
                errors++; $display("FAIL single_byte%0d: grant=%b m_valid=%b m_data=%h s_ready=%b expected 0010 1 %h 0010",
                                   b, grant, m_valid, m_data, s_ready, bytes[b]);
            end
            step();
        end
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b busy=%b expected 0000 0", grant, busy); end
        s_valid = '0; s_last = '0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        int         idx;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
        do_reset();
        s_valid = 4'b1111; s_last = 4'b1111; m_ready = 1'b1;
        for (int i = 0; i < N; i++) s_data[8*i +: 8] = 8'h10 + 8'(i);
        for (int g = 0; g < 5; g++) begin
            step(); #1;
            idx = g % N;
            checks++; if (grant !== order[g] || m_data !== 8'h10 + 8'(idx)) begin
                errors++; $display("FAIL rr_grant%0d: grant=%b m_data=%h expected %b %h", g, grant, m_data, order[g], 8'h10 + 8'(idx));
            end
            step(); #1;
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_bubble%0d: got %b expected 0000", g, grant); end
        end
        s_valid = '0; s_last = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [4];
        int idx, hs, stall;
        bytes[0] = 8'h31; bytes[1] = 8'h32; bytes[2] = 8'h33; bytes[3] = 8'h34;
        idx = 0; hs = 0; stall = 0;
        do_reset();
        s_valid = 4'b1000;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            s_data[31:24] = bytes[idx]; s_last[3] = (idx == 3);
            m_ready = !(idx == 2 && stall < 5);
            #1;
            if (idx == 2 && stall < 5) begin
                checks++; if (m_data !== 8'h33 || m_valid !== 1'b1 || s_ready[3] !== 1'b0) begin
                    errors++; $display("FAIL bp_hold%0d: m_data=%h m_valid=%b s_ready3=%b expected 33 1 0", stall, m_data, m_valid, s_ready[3]);
                end
                stall++;
            end
            if (m_valid && m_ready) begin hs++; idx++; end
            step();
        end
        #1;
        checks++; if (hs !== 4 || stall !== 5 || grant !== 4'b0000) begin
            errors++; $display("FAIL bp_total: handshakes=%0d stalls=%0d grant=%b expected 4 5 0000", hs, stall, grant);
        end
        s_valid = '0; s_last = '0;
        step();
    endtask

    task automatic test_trunc();
        logic [7:0] bytes [20];
        for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom);
        do_reset();
        s_valid = 4'b0100; s_data[23:16] = bytes[0]; m_ready = 1'b1;
        step(); #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL trunc_grant: got %b expected 0100", grant); end
        for (int i = 0; i < 16; i++) begin
            s_data[23:16] = bytes[i];
            #1;
            checks++; if (m_valid !== 1'b1 || m_data !== bytes[i] || trunc !== 1'b0) begin
                errors++; $display("FAIL trunc_byte%0d: m_valid=%b m_data=%h trunc=%b expected 1 %h 0", i, m_valid, m_data, trunc, bytes[i]);
            end
            step();
        end
        #1;
        checks++; if (trunc !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL trunc_pulse: trunc=%b grant=%b busy=%b expected 1 0000 0", trunc, grant, busy);
        end
        // Req3 also asks now; the pointer moved past req2, so req3 must win.
        s_valid = 4'b1100; s_data[31:24] = 8'h77; s_last[3] = 1'b1; s_data[23:16] = bytes[16];
        step(); #1;
        checks++; if (trunc !== 1'b0 || grant !== 4'b1000 || m_data !== 8'h77) begin
            errors++; $display("FAIL trunc_rrptr: trunc=%b grant=%b m_data=%h expected 0 1000 77", trunc, grant, m_data);
        end
        step();
        s_valid = 4'b0100; s_last = '0;
        step(); #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL trunc_regrant: got %b expected 0100", grant); end
        for (int i = 16; i < 20; i++) begin
            s_data[23:16] = bytes[i];
            #1;
            checks++; if (m_valid !== 1'b1 || m_data !== bytes[i]) begin
                errors++; $display("FAIL trunc_rest%0d: m_valid=%b m_data=%h expected 1 %h", i, m_valid, m_data, bytes[i]);
            end
            step();
        end
        #1;
        checks++; if (grant !== 4'b0100 || trunc !== 1'b0) begin errors++; $display("FAIL trunc_hold: grant=%b trunc=%b expected 0100 0", grant, trunc); end
        s_valid = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        s_valid = 4'b0001; m_ready = 1'b1;
        step();
        s_valid = '0;
        for (int c = 1; c < TMO; c++) begin
            step(); #1;
            checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++; $display("FAIL tmo_wait%0d: grant=%b timeout=%b expected 0001 0", c, grant, timeout);
            end
        end
        step(); #1;
`ifdef UART_ARB_TIMEOUT_EN
        checks++; if (grant !== 4'b0000 || timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_release: grant=%b timeout=%b expected 0000 1", grant, timeout);
        end
        step(); #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: timeout=%b expected 0", timeout); end
`else
        checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_off_hold: grant=%b timeout=%b expected 0001 0", grant, timeout);
        end
        for (int c = 0; c < 10; c++) step();
        #1;
        checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_off_late: grant=%b timeout=%b expected 0001 0", grant, timeout);
        end
`endif
    endtask

    // Random traffic against a transaction-level model: owner index, pointer, per-packet count.
    task automatic test_random();
        int owner, ptr, cnt, idle, cand, np, len;
        logic exp_trunc, exp_tmo, is_last, done;
        logic [3:0] exp_grant;
        do_reset();
        for (int i = 0; i < N; i++) begin
            wr[i] = 0; rd[i] = 0;
            np = $urandom_range(2, 4);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 20);
                for (int b = 0; b < len; b++) begin
                    mem[i][wr[i]] = {(b == len - 1), 8'($urandom)};
                    wr[i]++;
                end
            end
        end
        owner = -1; ptr = 0; cnt = 0; idle = 0; exp_trunc = 1'b0; exp_tmo = 1'b0; done = 1'b0;
        for (int c = 0; c < 8000 && !done; c++) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i]       = (rd[i] < wr[i]) && ($urandom_range(0, 9) < 8);
                s_data[8*i +: 8] = (rd[i] < wr[i]) ? mem[i][rd[i]][7:0] : 8'h00;
                s_last[i]        = (rd[i] < wr[i]) ? mem[i][rd[i]][8] : 1'b0;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_grant = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
            checks++; if (grant !== exp_grant || busy !== (owner >= 0) || trunc !== exp_trunc || timeout !== exp_tmo) begin
                errors++; $display("FAIL rnd_state c%0d: grant=%b busy=%b trunc=%b timeout=%b expected %b %b %b %b",
                                   c, grant, busy, trunc, timeout, exp_grant, (owner >= 0), exp_trunc, exp_tmo);
            end
            if (owner >= 0) begin
                checks++; if (m_valid !== s_valid[owner] || s_ready !== (m_ready ? exp_grant : 4'b0000)) begin
                    errors++; $display("FAIL rnd_hs c%0d: m_valid=%b s_ready=%b expected %b %b", c, m_valid, s_ready,
                                       s_valid[owner], (m_ready ? exp_grant : 4'b0000));
                end
                if (s_valid[owner]) begin
                    checks++; if (m_data !== mem[owner][rd[owner]][7:0]) begin
                        errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c, m_data, mem[owner][rd[owner]][7:0]);
                    end
                end
            end else begin
                checks++; if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
                    errors++; $display("FAIL rnd_idle c%0d: m_valid=%b s_ready=%b expected 0 0000", c, m_valid, s_ready);
                end
            end
            exp_trunc = 1'b0; exp_tmo = 1'b0;
            if (owner < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    cand = (ptr + k) % N;
                    if (s_valid[cand]) owner = cand;
                end
                cnt = 0; idle = 0;
            end else if (s_valid[owner] && m_ready) begin
                is_last = mem[owner][rd[owner]][8];
                rd[owner]++; cnt++; idle = 0;
                if (is_last || cnt == MAXLEN) begin
                    exp_trunc = !is_last; ptr = (owner + 1) % N; owner = -1;
                end
            end else if (!s_valid[owner]) begin
`ifdef UART_ARB_TIMEOUT_EN
                idle++;
                if (idle == TMO) begin exp_tmo = 1'b1; ptr = (owner + 1) % N; owner = -1; end
`endif
            end else begin
                idle = 0;
            end
            done = (owner < 0);
            for (int i = 0; i < N; i++) if (rd[i] < wr[i]) done = 1'b0;
            step();
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (rd[i] !== wr[i]) begin errors++; $display("FAIL rnd_drain req%0d: sent %0d expected %0d", i, rd[i], wr[i]); end
        end
        s_valid = '0; s_last = '0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_trunc();
        test_timeout();
        test_random();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
